// File: rtl/sram_host_seq_if.sv
// Host-side request/response bundle for sram_host_seq.
// The sequencer connects through the slave modport, the requesting logic through master.
interface sram_host_seq_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              iREQ;
  logic              iWR;
  logic [ADDR_W-1:0] iADDR;
  logic [DATA_W-1:0] iWDATA;
  logic [1:0]        iBE;
  logic              oREADY;
  logic              oDONE;
  logic [DATA_W-1:0] oRDATA;

  modport master (
    output iREQ, iWR, iADDR, iWDATA, iBE,
    input  oREADY, oDONE, oRDATA
  );

  modport slave (
    input  iREQ, iWR, iADDR, iWDATA, iBE,
    output oREADY, oDONE, oRDATA
  );
endinterface

// File: rtl/sram_host_seq.sv
// Host-side sequencer for the 256K x 16 asynchronous SRAM: IDLE -> SETUP -> ACCESS x WAIT_CYCLES -> HOLD.
// Define SRAM_SEQ_PIPE_EN to accept the next request during HOLD and skip the IDLE cycle.
module sram_host_seq #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  sram_host_seq_if.slave    host,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  output logic [DATA_W-1:0] oSRAM_WDATA,
  input  logic [DATA_W-1:0] iSRAM_RDATA,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_CE_N,
  output logic              oSRAM_UB_N,
  output logic              oSRAM_LB_N
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

`ifdef SRAM_SEQ_PIPE_EN
  localparam logic HOLD_READY = 1'b1;
`else
  localparam logic HOLD_READY = 1'b0;
`endif

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     state;
  state_t     nextState;
  logic [3:0] cnt;
  logic [3:0] cntNext;
  logic       accept;
  logic       wrR;
  logic [1:0] beR;
  logic       curWr;
  logic [1:0] curBe;
  logic       readyNext;
  logic       doneNext;
  logic       weNext;
  logic       oeNext;
  logic       ceNext;
  logic       ubNext;
  logic       lbNext;

  assign accept = host.iREQ & host.oREADY;

  // State and wait counter register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
    end
  end

  // Next-state and counter logic
  always_comb begin
    nextState = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (accept) nextState = SETUP;
        else        nextState = IDLE;
      end
      SETUP: begin
        nextState = ACCESS;
        cntNext   = CNT_LOAD;
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          nextState = HOLD;
        end else begin
          nextState = ACCESS;
          cntNext   = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (accept) nextState = SETUP;
        else        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
        cntNext   = 4'd0;
      end
    endcase
  end

  // Strobe/handshake values for the state being entered; the request just accepted supplies wr/be
  always_comb begin
    if (accept) begin
      curWr = host.iWR;
      curBe = host.iBE;
    end else begin
      curWr = wrR;
      curBe = beR;
    end
    readyNext = 1'b0;
    doneNext  = 1'b0;
    ceNext    = 1'b1;
    weNext    = 1'b1;
    oeNext    = 1'b1;
    ubNext    = 1'b1;
    lbNext    = 1'b1;
    case (nextState)
      IDLE: begin
        readyNext = 1'b1;
      end
      SETUP: begin
        ceNext = 1'b0;
        oeNext = curWr;
        ubNext = ~curBe[1];
        lbNext = ~curBe[0];
      end
      ACCESS: begin
        ceNext = 1'b0;
        oeNext = curWr;
        weNext = ~curWr;
        ubNext = ~curBe[1];
        lbNext = ~curBe[0];
      end
      HOLD: begin
        ceNext    = 1'b0;
        ubNext    = ~curBe[1];
        lbNext    = ~curBe[0];
        doneNext  = 1'b1;
        readyNext = HOLD_READY;
      end
      default: begin
        readyNext = 1'b1;
      end
    endcase
  end

  // Registered outputs, request latch and read-data capture
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      host.oREADY <= 1'b1;
      host.oDONE  <= 1'b0;
      host.oRDATA <= {DATA_W{1'b0}};
      oSRAM_ADDR  <= {ADDR_W{1'b0}};
      oSRAM_WDATA <= {DATA_W{1'b0}};
      oSRAM_WE_N  <= 1'b1;
      oSRAM_OE_N  <= 1'b1;
      oSRAM_CE_N  <= 1'b1;
      oSRAM_UB_N  <= 1'b1;
      oSRAM_LB_N  <= 1'b1;
      wrR         <= 1'b0;
      beR         <= 2'b00;
    end else begin
      host.oREADY <= readyNext;
      host.oDONE  <= doneNext;
      oSRAM_WE_N  <= weNext;
      oSRAM_OE_N  <= oeNext;
      oSRAM_CE_N  <= ceNext;
      oSRAM_UB_N  <= ubNext;
      oSRAM_LB_N  <= lbNext;
      if (accept) begin
        wrR        <= host.iWR;
        beR        <= host.iBE;
        oSRAM_ADDR <= host.iADDR;
        if (host.iWR) oSRAM_WDATA <= host.iWDATA;
      end
      // Sample the bus on the last strobe cycle so data is valid alongside oDONE
      if ((state == ACCESS) && (cnt == 4'd0) && !wrR) begin
        host.oRDATA <= iSRAM_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_sram_host_seq.sv
// Scoreboard bench for sram_host_seq: two instances (WAIT_CYCLES=2 and 1) driving SRAM models.
module tb_sram_host_seq;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int WA = 2;
  localparam int WB = 1;
`ifdef SRAM_SEQ_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  sram_host_seq_if #(.ADDR_W(AW), .DATA_W(DW)) busA ();
  sram_host_seq_if #(.ADDR_W(AW), .DATA_W(DW)) busB ();

  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] wdA, wdB, rdA, rdB;
  logic weA, oeA, ceA, ubA, lbA;
  logic weB, oeB, ceB, ubB, lbB;

  sram_host_seq #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WA)) dutA (
    .iCLK(clk), .iRST(rst), .host(busA),
    .oSRAM_ADDR(addrA), .oSRAM_WDATA(wdA), .iSRAM_RDATA(rdA),
    .oSRAM_WE_N(weA), .oSRAM_OE_N(oeA), .oSRAM_CE_N(ceA), .oSRAM_UB_N(ubA), .oSRAM_LB_N(lbA)
  );

  sram_host_seq #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WB)) dutB (
    .iCLK(clk), .iRST(rst), .host(busB),
    .oSRAM_ADDR(addrB), .oSRAM_WDATA(wdB), .iSRAM_RDATA(rdB),
    .oSRAM_WE_N(weB), .oSRAM_OE_N(oeB), .oSRAM_CE_N(ceB), .oSRAM_UB_N(ubB), .oSRAM_LB_N(lbB)
  );

  // Asynchronous SRAM models with a bench preload port
  logic [15:0] memA [0:262143];
  logic [15:0] memB [0:262143];
  logic plEnA, plEnB;
  logic [AW-1:0] plAddrA, plAddrB;
  logic [DW-1:0] plDataA, plDataB;

  assign rdA = (!ceA && !oeA) ? memA[addrA] : 16'hDEAD;
  assign rdB = (!ceB && !oeB) ? memB[addrB] : 16'hDEAD;

  always @(posedge clk) begin
    if (plEnA) memA[plAddrA] <= plDataA;
    else if (!ceA && !weA) begin
      if (!ubA) memA[addrA][15:8] <= wdA[15:8];
      if (!lbA) memA[addrA][7:0]  <= wdA[7:0];
    end
  end

  always @(posedge clk) begin
    if (plEnB) memB[plAddrB] <= plDataB;
    else if (!ceB && !weB) begin
      if (!ubB) memB[addrB][15:8] <= wdB[15:8];
      if (!lbB) memB[addrB][7:0]  <= wdB[7:0];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard state: expected oRDATA per completed transaction and accept edge numbers
  logic [15:0] expA[$];
  logic [15:0] expB[$];
  int accA[$];
  int accB[$];
  int cycA = 0;
  int cycB = 0;

  always @(posedge clk) begin
    cycA <= cycA + 1;
    cycB <= cycB + 1;
    if (rst) begin
      accA.delete();
      accB.delete();
    end else begin
      if (busA.iREQ && busA.oREADY) accA.push_back(cycA);
      if (busB.iREQ && busB.oREADY) accB.push_back(cycB);
    end
  end

  logic prevWeA = 1'b1;
  logic [AW-1:0] prevAddrA;
  logic [DW-1:0] prevWdA;

  // Monitor A: pops expectations on oDONE and checks pin invariants every cycle
  always @(negedge clk) begin
    if (!rst && busA.oDONE) begin
      if (expA.size() == 0) chk("A_done_unexpected", 32'(busA.oDONE), 32'd0);
      else chk("A_rdata", 32'(busA.oRDATA), 32'(expA.pop_front()));
      if (accA.size() == 0) chk("A_accept_missing", 32'(busA.oDONE), 32'd0);
      else chk("A_latency", 32'(cycA - accA.pop_front()), 32'(WA + 2));
    end
    chk("A_we_oe_both_low", 32'(!weA && !oeA), 32'd0);
    chk("A_we_without_ce", 32'(!weA && ceA), 32'd0);
    if (!weA && !prevWeA) begin
      chk("A_addr_stable", 32'(addrA), 32'(prevAddrA));
      chk("A_wdata_stable", 32'(wdA), 32'(prevWdA));
    end
    prevWeA   = weA;
    prevAddrA = addrA;
    prevWdA   = wdA;
  end

  // Monitor B: read data and transaction length
  always @(negedge clk) begin
    if (!rst && busB.oDONE) begin
      if (expB.size() == 0) chk("B_done_unexpected", 32'(busB.oDONE), 32'd0);
      else chk("B_rdata", 32'(busB.oRDATA), 32'(expB.pop_front()));
      if (accB.size() == 0) chk("B_accept_missing", 32'(busB.oDONE), 32'd0);
      else chk("B_latency", 32'(cycB - accB.pop_front()), 32'(WB + 2));
    end
  end

  // Issue one request on A from a negedge; optionally trace strobes through SETUP..HOLD
  task automatic reqA(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [1:0] be, input logic [DW-1:0] expRd, input bit trace);
    int n = 0;
    logic [4:0] expVec;
    while (busA.oREADY !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("A_ready_wait", 32'(busA.oREADY), 32'd1);
    busA.iREQ = 1'b1; busA.iWR = wr; busA.iADDR = a; busA.iWDATA = d; busA.iBE = be;
    expA.push_back(expRd);
    @(negedge clk);
    busA.iREQ = 1'b0; busA.iWR = ~wr; busA.iADDR = ~a; busA.iWDATA = ~d; busA.iBE = ~be;
    if (trace) begin
      for (int p = 0; p <= WA + 1; p++) begin
        expVec[4] = 1'b0;
        if (p == 0)           begin expVec[3] = 1'b1; expVec[2] = wr;   end
        else if (p <= WA)     begin expVec[3] = ~wr;  expVec[2] = wr;   end
        else                  begin expVec[3] = 1'b1; expVec[2] = 1'b1; end
        expVec[1] = ~be[1];
        expVec[0] = ~be[0];
        chk($sformatf("A_strobes_p%0d", p), 32'({ceA, weA, oeA, ubA, lbA}), 32'(expVec));
        chk($sformatf("A_addr_p%0d", p), 32'(addrA), 32'(a));
        if (wr) chk($sformatf("A_wdata_p%0d", p), 32'(wdA), 32'(d));
        chk($sformatf("A_ready_p%0d", p), 32'(busA.oREADY), (p == WA + 1) ? 32'(PIPE) : 32'd0);
        chk($sformatf("A_done_p%0d", p), 32'(busA.oDONE), (p == WA + 1) ? 32'd1 : 32'd0);
        @(negedge clk);
      end
      chk("A_idle_strobes", 32'({ceA, weA, oeA, ubA, lbA}), 32'h1F);
      chk("A_idle_ready", 32'(busA.oREADY), 32'd1);
    end
  endtask

  task automatic reqB(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [1:0] be, input logic [DW-1:0] expRd);
    int n = 0;
    while (busB.oREADY !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("B_ready_wait", 32'(busB.oREADY), 32'd1);
    busB.iREQ = 1'b1; busB.iWR = wr; busB.iADDR = a; busB.iWDATA = d; busB.iBE = be;
    expB.push_back(expRd);
    @(negedge clk);
    busB.iREQ = 1'b0;
    repeat (WB + 2) @(negedge clk);
  endtask

  logic [AW-1:0] contAddr [4];
  logic [DW-1:0] contData [4];

  initial begin
    int prevAcc;
    int n;
    rst = 1'b1;
    busA.iREQ = 1'b0; busA.iWR = 1'b0; busA.iADDR = '0; busA.iWDATA = '0; busA.iBE = 2'b00;
    busB.iREQ = 1'b0; busB.iWR = 1'b0; busB.iADDR = '0; busB.iWDATA = '0; busB.iBE = 2'b00;
    plEnA = 1'b0; plAddrA = '0; plDataA = '0;
    plEnB = 1'b0; plAddrB = '0; plDataB = '0;
    @(negedge clk);
    plEnA = 1'b1; plAddrA = 18'h00010; plDataA = 16'h1234;
    plEnB = 1'b1; plAddrB = 18'h00020; plDataB = 16'h7E57;
    @(negedge clk);
    plAddrA = 18'h3FFFF; plDataA = 16'h1111;
    plEnB = 1'b0;
    @(negedge clk);
    plEnA = 1'b0;
    @(negedge clk);
    chk("rst_strobes", 32'({ceA, weA, oeA, ubA, lbA}), 32'h1F);
    chk("rst_ready", 32'(busA.oREADY), 32'd1);
    chk("rst_done", 32'(busA.oDONE), 32'd0);
    chk("rst_rdata", 32'(busA.oRDATA), 32'd0);
    chk("rst_addr", 32'(addrA), 32'd0);
    chk("rst_wdata", 32'(wdA), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    reqA(1'b0, 18'h00010, 16'h0000, 2'b11, 16'h1234, 1'b1);
    reqA(1'b1, 18'h1ABCD, 16'hBEEF, 2'b11, 16'h1234, 1'b1);
    chk("memA_1ABCD", 32'(memA[18'h1ABCD]), 32'h0000BEEF);
    reqA(1'b1, 18'h3FFFF, 16'hA55A, 2'b01, 16'h1234, 1'b1);
    chk("memA_3FFFF_lower_lane", 32'(memA[18'h3FFFF]), 32'h0000115A);
    reqA(1'b0, 18'h3FFFF, 16'h0000, 2'b00, 16'h115A, 1'b1);

    // Reset in the middle of a write
    busA.iREQ = 1'b1; busA.iWR = 1'b1; busA.iADDR = 18'h00100; busA.iWDATA = 16'h7777; busA.iBE = 2'b11;
    @(negedge clk);
    busA.iREQ = 1'b0;
    @(negedge clk);
    chk("midrst_in_access", 32'(weA), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_strobes", 32'({ceA, weA, oeA, ubA, lbA}), 32'h1F);
    chk("midrst_ready", 32'(busA.oREADY), 32'd1);
    chk("midrst_done", 32'(busA.oDONE), 32'd0);
    chk("midrst_rdata", 32'(busA.oRDATA), 32'd0);
    @(negedge clk);

    // iREQ held high with alternating addresses
    contAddr[0] = 18'h5; contData[0] = 16'hA005;
    contAddr[1] = 18'h6; contData[1] = 16'hA006;
    contAddr[2] = 18'h5; contData[2] = 16'hB005;
    contAddr[3] = 18'h6; contData[3] = 16'hB006;
    prevAcc = 0;
    busA.iREQ = 1'b1; busA.iWR = 1'b1; busA.iBE = 2'b11;
    busA.iADDR = contAddr[0]; busA.iWDATA = contData[0];
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (busA.oREADY !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("cont_ready_wait", 32'(busA.oREADY), 32'd1);
      expA.push_back(16'h0000);
      @(negedge clk);
      chk("cont_setup_we", 32'(weA), 32'd1);
      chk("cont_setup_ce", 32'(ceA), 32'd0);
      chk("cont_setup_addr", 32'(addrA), 32'(contAddr[k]));
      if (k > 0) chk("cont_spacing", 32'(cycA - prevAcc), PIPE ? 32'(WA + 2) : 32'(WA + 3));
      prevAcc = cycA;
      if (k < 3) begin
        busA.iADDR = contAddr[k+1];
        busA.iWDATA = contData[k+1];
      end else begin
        busA.iREQ = 1'b0;
      end
    end
    repeat (WA + 4) @(negedge clk);
    chk("cont_mem5", 32'(memA[18'h5]), 32'h0000B005);
    chk("cont_mem6", 32'(memA[18'h6]), 32'h0000B006);

    // Shortest wait setting: read then write the same word
    reqB(1'b0, 18'h00020, 16'h0000, 2'b11, 16'h7E57);
    reqB(1'b1, 18'h00020, 16'h4242, 2'b11, 16'h7E57);
    chk("memB_20", 32'(memB[18'h00020]), 32'h00004242);

    repeat (6) @(negedge clk);
    chk("A_queue_drained", 32'(expA.size()), 32'd0);
    chk("B_queue_drained", 32'(expB.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_host_seq.md
Name: sram_host_seq

Overview:
- Host-side transaction sequencer for the board's 256K x 16 asynchronous SRAM.
- Turns single-cycle read/write requests (valid/ready handshake) into correctly timed chip-enable, output-enable, write-enable, byte-lane, address and data strobes.
- Drives the host-side pins of the SRAM pin bridge and registers returned read data.
- Used by the keyboard logging path to store and replay scancodes.

Parameters:
- ADDR_W, 18, address width in 16-bit words.
- DATA_W, 16, data width; byte lanes fixed at 2, so DATA_W must be 16.
- WAIT_CYCLES, 2, number of ACCESS-state cycles (strobe-active time); legal range 1..15.

Ports:
- iCLK  in  1  system clock; all logic on rising edge.
- iRST  in  1  synchronous reset, active-high.
- iREQ  in  1  request valid.
- iWR  in  1  1 = write, 0 = read; sampled with iREQ.
- iADDR  in  ADDR_W  word address.
- iWDATA  in  DATA_W  write data.
- iBE  in  2  byte enables; bit1 = upper lane, bit0 = lower lane; active-high.
- oREADY  out  1  request accepted this cycle if iREQ=1.
- oDONE  out  1  one-cycle pulse at transaction end.
- oRDATA  out  DATA_W  last read data; held until the next read completes.
- oSRAM_ADDR  out  ADDR_W  to bridge address input.
- oSRAM_WDATA  out  DATA_W  to bridge data input.
- iSRAM_RDATA  in  DATA_W  from bridge data output.
- oSRAM_WE_N, oSRAM_OE_N, oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N  out  1 each  active-low strobes to bridge.

Behaviour:
- Reset, applied at the next edge while iRST=1, from any state including mid-access:
  - state=IDLE, counter=0.
  - oREADY=1, oDONE=0, oRDATA=0, oSRAM_ADDR=0, oSRAM_WDATA=0.
  - All five strobes =1 (deasserted).
- Handshake:
  - A request is accepted on a rising edge where iREQ=1 and oREADY=1.
  - iWR, iADDR, iWDATA and iBE are latched at acceptance; later changes are ignored.
  - iREQ while oREADY=0 is ignored and not queued.
- States (all outputs registered):
  - IDLE: oREADY=1; strobes high. On accept -> SETUP.
  - SETUP, 1 cycle:
    - oREADY=0; CE_N=0; address driven.
    - UB_N=~BE[1], LB_N=~BE[0].
    - Read: OE_N=0. Write: WDATA driven, WE_N=1, OE_N=1.
    - Counter loaded to WAIT_CYCLES-1. -> ACCESS.
  - ACCESS, WAIT_CYCLES cycles: same as SETUP, except writes drive WE_N=0. Counter decrements; at 0 -> HOLD.
    - Read: iSRAM_RDATA is captured into oRDATA on the edge leaving ACCESS.
  - HOLD, 1 cycle:
    - WE_N=1 and OE_N=1.
    - CE_N, address, byte lanes and WDATA stay unchanged (hold time).
    - oDONE=1. -> IDLE.
- Timing:
  - Transaction length from the accept edge to the return to IDLE is WAIT_CYCLES+2 cycles.
  - oDONE is high the cycle after the last ACCESS cycle.
  - Read data is valid on oRDATA in the same cycle oDONE=1.
  - Throughput is one transaction per WAIT_CYCLES+3 cycles.
- Invariants:
  - WE_N and OE_N are never both 0.
  - WE_N is never 0 while CE_N=1.
  - Address and WDATA never change while WE_N=0.
- iBE=2'b00: the transaction still runs with both lanes deasserted. oDONE still pulses. For a read, oRDATA still captures the bus.
- Address wrap is not applicable; iADDR is used verbatim.
- oRDATA is unchanged by writes.

Optional Feature:
- Macro SRAM_SEQ_PIPE_EN.
- Defined:
  - oREADY=1 in HOLD as well as in IDLE.
  - A request accepted in HOLD goes directly to SETUP, skipping IDLE.
  - In the following SETUP cycle CE_N stays 0 and the new address is driven; WE_N is guaranteed 1 in that cycle.
  - Back-to-back throughput becomes WAIT_CYCLES+2 cycles per transaction.
- Undefined: oREADY=1 only in IDLE; behaviour exactly as above.

Test Plan:
- Reset mid-write (iRST during ACCESS, WAIT_CYCLES=2) -> next cycle all strobes 1, oREADY=1, oRDATA=0, state IDLE.
- Write 0x1ABCD <- 0xBEEF, iBE=11 -> SETUP: CE_N=0, WE_N=1. Two ACCESS cycles: WE_N=0, addr 0x1ABCD, data 0xBEEF. HOLD: WE_N=1, oDONE=1. Total 4 cycles.
- Read 0x00010, model returns 0x1234 -> OE_N=0 for SETUP+ACCESS. oRDATA=0x1234 with oDONE. oRDATA holds 0x1234 through a subsequent write.
- Byte write iBE=01 to 0x3FFFF, data 0xA55A -> UB_N=1, LB_N=0 throughout SETUP..HOLD; WE_N low 2 cycles.
- iREQ held high continuously (alternating addresses 0x5, 0x6) without SRAM_SEQ_PIPE_EN -> accepts spaced every 5 cycles, no request lost or duplicated. With SRAM_SEQ_PIPE_EN -> accepts every 4 cycles, and WE_N=1 in each SETUP.
- WAIT_CYCLES=1, read then write same address -> each transaction 3 cycles. Read returns the model's preloaded value, and the write value is present in the model afterwards.
